quad_encoder_gen: RTL

- Quadrature encoder emulator: the transmitting end of the QUAD_A/QUAD_B interface that the pong paddle logic decodes.
- Drives Gray-coded A/B phases from step commands at a programmable edge rate.
- Used in benches and on-board as a stimulus source wired into the pong top-level quadrature inputs.

---
 rtl/quad_encoder_gen_if.sv | 33 +++
 rtl/quad_encoder_gen.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : quad_encoder_gen_if
// Description : Step-command channel for the quadrature encoder emulator.
//               A command moves on a cycle where cmd_valid && cmd_ready.
//   cmd_valid  master->slave  command present
//   cmd_ready  slave->master  generator can accept a command
//   cmd_dir    master->slave  1 = forward (A leads B), 0 = reverse
//   cmd_steps  master->slave  number of quarter-step edges to emit
//   period     master->slave  clocks between edges (0 behaves as 1)
// Revision    : 1.0 - initial release
// ============================================================================
interface quad_encoder_gen_if #(
  parameter int CNT_W  = 16,
  parameter int PEND_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dir;
  logic [PEND_W-1:0] cmd_steps;
  logic [CNT_W-1:0]  period;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, period,
    output cmd_ready
  );
endinterface
`default_nettype wire

// File: rtl/quad_encoder_gen.sv
`default_nettype none
// ============================================================================
// Module      : quad_encoder_gen
// Description : Quadrature encoder emulator. Turns step commands into
//               Gray-coded A/B phase edges, one edge every `period` clocks,
//               and keeps a signed running edge count.
// Ports       : CLOCK_50  system clock
//               RESET     asynchronous active-low reset
//               cmd       step-command channel (slave side)
//               QUAD_A    phase A (registered)
//               QUAD_B    phase B (registered)
//               busy      command in progress (registered)
//               position  signed running edge count, wraps at 2^POS_W
//               QUAD_I    index pulse, only with QUAD_INDEX_EN defined
// Options     : QUAD_INDEX_EN - adds QUAD_I and parameter INDEX_EDGES
// Revision    : 1.0 - initial release
// ============================================================================
module quad_encoder_gen #(
  parameter int CNT_W  = 16,
  parameter int PEND_W = 8,
  parameter int POS_W  = 16
`ifdef QUAD_INDEX_EN
  ,
  parameter int INDEX_EDGES = 400
`endif
) (
  input  wire logic           CLOCK_50,
  input  wire logic           RESET,
  quad_encoder_gen_if.slave   cmd,
  output logic                QUAD_A,
  output logic                QUAD_B,
  output logic                busy,
  output logic [POS_W-1:0]    position
`ifdef QUAD_INDEX_EN
  ,
  output logic                QUAD_I
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              w_accept;
  logic              w_edge;

  logic              r_ready;
  logic              r_busy;
  logic              r_dir;
  logic [PEND_W-1:0] r_remaining;
  logic [CNT_W-1:0]  r_period;
  logic [CNT_W-1:0]  r_div;
  logic [CNT_W-1:0]  w_period_eff;

  logic              r_a;
  logic              r_b;
  logic              w_a_next;
  logic              w_b_next;
  logic [POS_W-1:0]  r_pos;
  logic [POS_W-1:0]  w_pos_next;

  // A zero period would never let the divider expire; treat it as 1.
  assign w_period_eff = (cmd.period == '0) ? CNT_W'(1) : cmd.period;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_edge       = 1'b0;
    case (r_state)
      S_IDLE: begin
        // r_ready is low in the first IDLE cycle after reset release.
        if (cmd.cmd_valid && r_ready) begin
          w_accept     = 1'b1;
          w_state_next = (cmd.cmd_steps == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (r_div == '0) begin
          w_edge = 1'b1;
          if (r_remaining == PEND_W'(1)) w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Phase stepping. Forward: toggle A when A==B, else B (00,10,11,01).
  // Reverse: toggle B when A==B, else A (00,01,11,10). One bit per edge.
  // --------------------------------------------------------------------------
  always_comb begin
    w_a_next   = r_a;
    w_b_next   = r_b;
    w_pos_next = r_pos;
    if (w_edge) begin
      if (r_dir) begin
        if (r_a == r_b) w_a_next = ~r_a;
        else            w_b_next = ~r_b;
        w_pos_next = r_pos + POS_W'(1);
      end else begin
        if (r_a == r_b) w_b_next = ~r_b;
        else            w_a_next = ~r_a;
        w_pos_next = r_pos - POS_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) begin
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_dir       <= 1'b0;
      r_remaining <= '0;
      r_period    <= CNT_W'(1);
      r_div       <= '0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_pos       <= '0;
    end else begin
      // Flags follow the state being entered so they stay flop outputs.
      r_ready <= (w_state_next == S_IDLE);
      r_busy  <= (w_state_next == S_RUN);
      r_a     <= w_a_next;
      r_b     <= w_b_next;
      r_pos   <= w_pos_next;
      if (w_accept) begin
        r_dir       <= cmd.cmd_dir;
        r_remaining <= cmd.cmd_steps;
        r_period    <= w_period_eff;
        r_div       <= w_period_eff - CNT_W'(1);
      end else if (r_state == S_RUN) begin
        if (w_edge) begin
          r_remaining <= r_remaining - PEND_W'(1);
          r_div       <= r_period - CNT_W'(1);
        end else begin
          r_div <= r_div - CNT_W'(1);
        end
      end
    end
  end

`ifdef QUAD_INDEX_EN
  // Index marks the 00 phase at every multiple of INDEX_EDGES, either sign.
  logic r_qi;
  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) begin
      r_qi <= 1'b1;
    end else if (w_edge) begin
      r_qi <= (!w_a_next && !w_b_next &&
               ((int'($signed(w_pos_next)) % INDEX_EDGES) == 0));
    end
  end
  assign QUAD_I = r_qi;
`endif

  assign cmd.cmd_ready = r_ready;
  assign busy          = r_busy;
  assign QUAD_A        = r_a;
  assign QUAD_B        = r_b;
  assign position      = r_pos;

endmodule
`default_nettype wire
